fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle decode/control path (ControlUNIT, RegFile, signextension). Owns the program counter, issues word fetches to instruction memory over a valid/ready request channel with variable-latency in-order responses, buffers returned instructions in a small FIFO, and presents them to decode with a valid/ready handshake. Branch/jump redirects from decode flush the buffer and discard in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- DEPTH, 4, instruction buffer entries; also the maximum outstanding-plus-buffered fetches (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address (current PC)
- imem_resp_valid  in  1  response valid (in request order, ≥1 cycle after acceptance, never back-pressured)
- imem_resp_data  in  32  fetched instruction
- redirect_valid  in  1  one-cycle pulse: branch taken or jump
- redirect_target  in  32  new PC; bits [1:0] ignored (forced to 0)
- dec_valid  out  1  buffer head valid
- dec_ready  in  1  decode consumes head
- dec_instr  out  32  instruction at head
- dec_pc  out  32  address of dec_instr
- dec_pcplus4  out  32  dec_pc + 4, mod 2^32

## Operation
- State: pc, FIFO of {instr, pc} (count 0..DEPTH), outstanding counter (0..DEPTH), drop counter (0..DEPTH), address FIFO of outstanding request PCs (DEPTH entries).
- Request issue: imem_req_valid = !rst && !redirect_valid && (count + outstanding < DEPTH). imem_req_addr = pc. On req handshake: pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0), push pc to address FIFO, outstanding++.
- Response: on imem_resp_valid, pop address FIFO, outstanding--. If drop > 0 or redirect_valid this cycle: discard, drop-- if drop > 0. Else push {imem_resp_data, popped pc} into instruction FIFO.
- Decode: dec_valid = count != 0; head fields combinational from FIFO head. Pop on dec_valid && dec_ready.
- Redirect (redirect_valid=1): pc <= {redirect_target[31:2], 2'b00}; instruction FIFO cleared; drop <= outstanding after this cycle's accounting (responses arriving this cycle already decremented); no request issued this cycle. A decode pop in the same cycle still counts as consumed.
- Simultaneous push+pop: count unchanged; full FIFO never overflows because issue is credit-limited.
- Response with outstanding == 0: protocol violation; ignored, no state change (assertion in bench).
- Reset: pc=RESET_PC, count=0, outstanding=0, drop=0, address FIFO empty. Reset mid-operation discards everything; responses to pre-reset requests are the memory's responsibility (memory is reset together).

## Timing
- Reset outputs: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_instr/dec_pc/dec_pcplus4 = don't-care (driven 0 when empty).
- First request: first cycle with rst=0.
- Fetch latency: request accepted cycle N, response cycle N+L (L≥1), dec_valid cycle N+L+1 (registered buffer, no bypass).
- Throughput: one instruction/cycle sustained with L ≤ DEPTH-2 and dec_ready=1.
- Redirect in cycle R: first request to target in cycle R+1; no pre-redirect instruction visible at decode from cycle R+1.
- Credit does not return in the pop cycle; freed slot usable the following cycle.

## Test plan
- Reset then L=1, dec_ready=1: requests 0x0,0x4,0x8,... in consecutive cycles from cycle 1; dec_pc 0x0 at cycle 3, then +4 each cycle; dec_pcplus4 = dec_pc+4.
- dec_ready=0 with L=1: exactly 4 requests issued (0x0–0xC), imem_req_valid then held 0; releasing dec_ready drains 0x0..0xC in order and fetching resumes at 0x10.
- Redirect to 0x0000_0103 with 2 requests in flight (L=3): both responses dropped, next request addr 0x100, next dec_pc 0x100; no stale instruction reaches decode.
- Redirect same cycle as a response and a decode pop: popped entry consumed once, response discarded, FIFO empty next cycle.
- RESET_PC=32'hFFFF_FFF8, L=1: request addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0; dec_pcplus4 for 0xFFFFFFFC is 0x0.
- imem_req_ready toggled randomly, L random 1..2, rst asserted mid-stream: after rst, outputs at reset values next cycle and fetch restarts at RESET_PC; scoreboard confirms in-order, gap-free dec_pc sequence.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches to imem and buffers
// in-order responses in a small FIFO feeding decode. Redirects flush the buffer and drop in-flight data.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pcplus4
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam logic [CntW:0] DepthCredit = (CntW + 1)'(DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q [DEPTH];
    logic [31:0] instr_d [DEPTH];
    logic [31:0] ipc_q   [DEPTH];
    logic [31:0] ipc_d   [DEPTH];
    logic [31:0] addr_q  [DEPTH];
    logic [31:0] addr_d  [DEPTH];
    ptr_t        wptr_q, wptr_d, rptr_q, rptr_d;
    ptr_t        awptr_q, awptr_d, arptr_q, arptr_d;
    cnt_t        count_q, count_d;
    cnt_t        outst_q, outst_d;
    cnt_t        drop_q, drop_d;

    logic        req_fire, resp_ok, push, pop;
    logic [CntW:0] credit_used;
    logic [31:0] resp_pc;
    logic        unused_tgt;

    assign unused_tgt = ^redirect_target[1:0];

    always_comb begin
        credit_used    = {1'b0, count_q} + {1'b0, outst_q};
        imem_req_valid = !rst && !redirect_valid && (credit_used < DepthCredit);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored entirely.
        resp_ok        = imem_resp_valid && (outst_q != '0);
        resp_pc        = addr_q[arptr_q];
        push           = resp_ok && (drop_q == '0) && !redirect_valid;
        dec_valid      = (count_q != '0);
        pop            = dec_valid && dec_ready;

        dec_instr   = dec_valid ? instr_q[rptr_q] : 32'h0;
        dec_pc      = dec_valid ? ipc_q[rptr_q] : 32'h0;
        dec_pcplus4 = dec_valid ? ipc_q[rptr_q] + 32'd4 : 32'h0;
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        addr_d  = addr_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        awptr_d = awptr_q;
        arptr_d = arptr_q;
        count_d = count_q;
        outst_d = outst_q;
        drop_d  = drop_q;

        if (req_fire) begin
            pc_d            = pc_q + 32'd4;
            addr_d[awptr_q] = pc_q;
            awptr_d         = awptr_q + ptr_t'(1);
        end
        if (resp_ok) begin
            arptr_d = arptr_q + ptr_t'(1);
        end
        outst_d = outst_q + cnt_t'(req_fire) - cnt_t'(resp_ok);

        if (resp_ok && (drop_q != '0)) begin
            drop_d = drop_q - cnt_t'(1);
        end

        if (push) begin
            instr_d[wptr_q] = imem_resp_data;
            ipc_d[wptr_q]   = resp_pc;
            wptr_d          = wptr_q + ptr_t'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + ptr_t'(1);
        end
        count_d = count_q + cnt_t'(push) - cnt_t'(pop);

        // Redirect: everything still in flight belongs to the wrong path.
        if (redirect_valid) begin
            pc_d    = {redirect_target[31:2], 2'b00};
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            drop_d  = outst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            wptr_q  <= '0;
            rptr_q  <= '0;
            awptr_q <= '0;
            arptr_q <= '0;
            count_q <= '0;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            awptr_q <= awptr_d;
            arptr_q <= arptr_d;
            count_q <= count_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        ipc_q   <= ipc_d;
        addr_q  <= addr_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with per-request latency and a
// running expectation of request addresses and decoded PCs.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_target;
    logic        redirect_valid, dec_valid, dec_ready;
    logic [31:0] dec_instr, dec_pc, dec_pcplus4;

    logic        rst2, req_valid2, resp_valid2;
    logic [31:0] req_addr2, resp_data2, dec_instr2, dec_pc2, dec_pcplus42;
    logic        dec_valid2;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pcplus4(dec_pcplus4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .rst(rst2),
        .imem_req_valid(req_valid2), .imem_req_ready(1'b1),
        .imem_req_addr(req_addr2), .imem_resp_valid(resp_valid2),
        .imem_resp_data(resp_data2), .redirect_valid(1'b0),
        .redirect_target(32'h0), .dec_valid(dec_valid2), .dec_ready(1'b1),
        .dec_instr(dec_instr2), .dec_pc(dec_pc2), .dec_pcplus4(dec_pcplus42)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc, last_due, lat, n_pops;
    bit          rand_lat;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_req, exp_dec;
    logic        s_req_valid, s_fire, s_dec_valid;
    logic [31:0] s_req_addr, s_dec_pc, s_dec_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Sample one cycle at negedge, score handshakes, then advance and drive the memory response.
    task automatic cycle();
        int d;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_fire      = imem_req_valid && imem_req_ready;
        s_dec_valid = dec_valid;
        s_dec_pc    = dec_pc;
        s_dec_instr = dec_instr;
        if (rst) begin
            mq.delete();
            last_due = 0;
            exp_req  = 32'h0;
            exp_dec  = 32'h0;
        end else begin
            if (s_fire) begin
                check_eq("req_addr", imem_req_addr, exp_req);
                exp_req = exp_req + 32'd4;
                d = cyc + (rand_lat ? int'($urandom_range(1, 2)) : lat);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq.push_back('{addr: imem_req_addr, due: d});
            end
            if (dec_valid && dec_ready) begin
                check_eq("dec_pc", dec_pc, exp_dec);
                check_eq("dec_pcplus4", dec_pcplus4, exp_dec + 32'd4);
                check_eq("dec_instr", dec_instr, mem_word(exp_dec));
                exp_dec = exp_dec + 32'd4;
                n_pops++;
            end
            if (redirect_valid) begin
                check_eq("req_blocked_on_redirect", {31'b0, imem_req_valid}, 32'h0);
                exp_req = {redirect_target[31:2], 2'b00};
                exp_dec = exp_req;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        check_eq("rst_req_valid", {31'b0, s_req_valid}, 32'h0);
        check_eq("rst_req_addr", s_req_addr, 32'h0);
        check_eq("rst_dec_valid", {31'b0, s_dec_valid}, 32'h0);
        check_eq("rst_dec_pc", s_dec_pc, 32'h0);
        check_eq("rst_dec_instr", s_dec_instr, 32'h0);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int          nreq, waited;
        logic [31:0] first_addr;
        logic        prev_fire;
        logic [31:0] prev_addr;
        logic [31:0] wrap_addr[3];

        rst = 1'b1; rst2 = 1'b1;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_target = 32'h0; dec_ready = 1'b1;
        resp_valid2 = 1'b0; resp_data2 = 32'h0;
        cyc = 0; last_due = 0; lat = 1; rand_lat = 1'b0; n_pops = 0;
        exp_req = 32'h0; exp_dec = 32'h0;

        // Streaming at L=1
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            cycle();
            check_eq("stream_req_valid", {31'b0, s_req_valid}, 32'h1);
            check_eq("stream_dec_valid", {31'b0, s_dec_valid}, (c >= 3) ? 32'h1 : 32'h0);
            if (c >= 3) check_eq("stream_dec_pc", s_dec_pc, 32'(4 * (c - 3)));
        end

        // Back-pressure: credit caps issue at DEPTH
        do_reset();
        dec_ready = 1'b0;
        nreq = 0;
        for (int c = 1; c <= 10; c++) begin
            cycle();
            if (s_fire) nreq++;
        end
        check_eq("bp_req_count", 32'(nreq), 32'd4);
        check_eq("bp_req_held", {31'b0, s_req_valid}, 32'h0);
        check_eq("bp_dec_valid", {31'b0, s_dec_valid}, 32'h1);
        dec_ready = 1'b1;
        n_pops = 0;
        first_addr = 32'hDEAD_DEAD;
        for (int c = 0; c < 20 && first_addr == 32'hDEAD_DEAD; c++) begin
            cycle();
            if (s_fire) first_addr = s_req_addr;
        end
        check_eq("bp_resume_addr", first_addr, 32'h10);
        check_eq("bp_drained_first", 32'(n_pops >= 1), 32'h1);

        // Redirect with two requests in flight, L=3
        do_reset();
        lat = 3;
        cycle();
        cycle();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check_eq("redir_req_valid", {31'b0, s_req_valid}, 32'h1);
        check_eq("redir_req_addr", s_req_addr, 32'h100);
        waited = 1;
        while (!s_dec_valid && waited < 20) begin
            cycle();
            waited++;
        end
        check_eq("redir_dec_seen", {31'b0, s_dec_valid}, 32'h1);
        check_eq("redir_dec_pc", s_dec_pc, 32'h100);
        check_eq("redir_dec_latency", 32'(waited), 32'd5);

        // Redirect coinciding with a response and a decode pop
        do_reset();
        lat = 1;
        for (int c = 1; c <= 4; c++) cycle();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
        cycle();
        check_eq("coinc_pop_valid", {31'b0, s_dec_valid}, 32'h1);
        check_eq("coinc_pop_pc", s_dec_pc, 32'h8);
        redirect_valid = 1'b0;
        cycle();
        check_eq("coinc_empty_r1", {31'b0, s_dec_valid}, 32'h0);
        cycle();
        check_eq("coinc_empty_r2", {31'b0, s_dec_valid}, 32'h0);
        cycle();
        check_eq("coinc_target_pc", s_dec_pc, 32'h200);

        // Random ready / latency with a mid-stream reset
        rand_lat = 1'b1;
        do_reset();
        n_pops = 0;
        for (int i = 0; i < 200; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            dec_ready      = 1'($urandom_range(0, 1));
            if (i == 90) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                cycle();
                check_eq("midrst_dec_valid", {31'b0, s_dec_valid}, 32'h0);
                check_eq("midrst_req_addr", s_req_addr, 32'h0);
            end else begin
                cycle();
            end
        end
        check_eq("rand_progress", 32'(n_pops >= 20), 32'h1);
        rand_lat = 1'b0;
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;

        // PC wrap on a second instance with RESET_PC near the top of memory
        wrap_addr[0] = 32'hFFFF_FFF8;
        wrap_addr[1] = 32'hFFFF_FFFC;
        wrap_addr[2] = 32'h0000_0000;
        @(negedge clk);
        check_eq("wrap_rst_addr", req_addr2, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        prev_fire = 1'b0;
        prev_addr = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            resp_valid2 = prev_fire;
            resp_data2  = mem_word(prev_addr);
            @(negedge clk);
            if (c <= 3) begin
                check_eq("wrap_req_valid", {31'b0, req_valid2}, 32'h1);
                check_eq("wrap_req_addr", req_addr2, wrap_addr[c-1]);
            end
            if (c == 3) check_eq("wrap_dec_pc0", dec_pc2, 32'hFFFF_FFF8);
            if (c == 4) begin
                check_eq("wrap_dec_pc1", dec_pc2, 32'hFFFF_FFFC);
                check_eq("wrap_dec_pcplus4", dec_pcplus42, 32'h0);
                check_eq("wrap_dec_instr", dec_instr2, mem_word(32'hFFFF_FFFC));
            end
            prev_fire = req_valid2;
            prev_addr = req_addr2;
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
